// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle strobe into a programmable-width level, with optional
// retrigger, a dead time after each pulse, and a saturating rejected-strobe count.
module pulse_stretcher #(
  parameter int CNT_W  = 8,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  input  logic [CNT_W-1:0]  width,
  input  logic [CNT_W-1:0]  holdoff,
  input  logic              retrig,
  output logic              out,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] hold_q, hold_nxt;
  logic             drop;

  // A width of zero behaves like a width of one.
  function automatic logic [CNT_W-1:0] width_load(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : w - CNT_W'(1);
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold_q;
    drop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in) begin
          state_nxt = ACTIVE;
          cnt_nxt   = width_load(width);
          hold_nxt  = holdoff;
        end
      end
      ACTIVE: begin
        if (in && retrig) begin
          cnt_nxt  = width_load(width);
          hold_nxt = holdoff;
        end else begin
          drop = in;
          if (cnt == '0) begin
            if (hold_q != '0) begin
              state_nxt = HOLDOFF;
              cnt_nxt   = hold_q - CNT_W'(1);
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      HOLDOFF: begin
        drop = in;
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so no input reaches them combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_q   <= '0;
      out      <= 1'b0;
      busy     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hold_q <= hold_nxt;
      out    <= (state_nxt == ACTIVE);
      busy   <= (state_nxt != IDLE);
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed and randomized bench for pulse_stretcher, checked against a
// time-window reference model (pulse/busy end cycles plus a drop tally).
module tb_pulse_stretcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_s;
  logic [7:0]  width;
  logic [7:0]  holdoff;
  logic        retrig;
  logic        out;
  logic        busy;
  logic [15:0] drop_cnt;

  int checks = 0;
  int passes = 0;

  // Reference model: the current pulse covers cycles up to act_end, the dead
  // time up to busy_end; everything later is idle.
  int          k        = 0;
  int          act_end  = -1;
  int          busy_end = -1;
  int          hlat     = 0;
  logic [15:0] m_drop   = '0;

  pulse_stretcher #(.CNT_W(8), .DROP_W(16)) dut (
    .clk(clk), .reset(reset), .in(in_s), .width(width), .holdoff(holdoff),
    .retrig(retrig), .out(out), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
  endtask

  task automatic model_update(input logic r, input logic i);
    int w;
    w = (width == 0) ? 1 : int'(width);
    if (r) begin
      act_end  = -1;
      busy_end = -1;
      m_drop   = '0;
    end else if (k > busy_end) begin
      if (i) begin
        hlat     = int'(holdoff);
        act_end  = k + w;
        busy_end = act_end + hlat;
      end
    end else if (k <= act_end && i && retrig) begin
      hlat     = int'(holdoff);
      act_end  = k + w;
      busy_end = act_end + hlat;
    end else if (i && m_drop != 16'hFFFF) begin
      m_drop = m_drop + 16'd1;
    end
  endtask

  task automatic step(input logic r, input logic i);
    reset = r;
    in_s  = i;
    @(posedge clk);
    model_update(r, i);
    k++;
    #1;
    chk("out",      {31'd0, out},      {31'd0, (k <= act_end)});
    chk("busy",     {31'd0, busy},     {31'd0, (k <= busy_end)});
    chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_drop});
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0);
    chk("rst_out",  {31'd0, out},      32'd0);
    chk("rst_busy", {31'd0, busy},     32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    idle(2);
  endtask

  initial begin
    reset = 1'b1; in_s = 1'b0; width = 8'd3; holdoff = 8'd0; retrig = 1'b0;
    #1;
    step(1'b1, 1'b0);
    do_reset();

    // width 3, no holdoff
    width = 8'd3; holdoff = 8'd0; retrig = 1'b0;
    step(1'b0, 1'b1);
    idle(5);
    chk("t1_drop", {16'd0, drop_cnt}, 32'd0);

    // width 0 acts as 1; a strobe two cycles later is accepted
    do_reset();
    width = 8'd0;
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    idle(3);
    chk("t2_drop", {16'd0, drop_cnt}, 32'd0);

    // retrigger extends the pulse
    do_reset();
    width = 8'd4; retrig = 1'b1;
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    idle(7);
    chk("t3_drop", {16'd0, drop_cnt}, 32'd0);

    // no retrigger: second strobe dropped
    do_reset();
    width = 8'd4; retrig = 1'b0;
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
    idle(5);
    chk("t4_drop", {16'd0, drop_cnt}, 32'd1);

    // holdoff: strobe during dead time dropped, first idle cycle accepted
    do_reset();
    width = 8'd2; holdoff = 8'd2;
    step(1'b0, 1'b1); idle(2); step(1'b0, 1'b1); step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("t5_out_acc", {31'd0, out}, 32'd1);
    idle(6);
    chk("t5_drop", {16'd0, drop_cnt}, 32'd1);

    // reset mid-pulse wins
    do_reset();
    width = 8'd5; holdoff = 8'd3;
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("t6_out",  {31'd0, out},  32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    idle(3);

    // randomized traffic, including config changes mid-pulse and stray resets
    for (int j = 0; j < 3000; j++) begin
      width   = 8'($urandom_range(0, 6));
      holdoff = 8'($urandom_range(0, 4));
      retrig  = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0));
    end

    // held-high input with long pulses drives the drop counter into saturation
    do_reset();
    width = 8'd255; holdoff = 8'd255; retrig = 1'b0;
    for (int j = 0; j < 70000; j++) step(1'b0, 1'b1);
    chk("sat_drop", {16'd0, drop_cnt}, 32'h0000FFFF);
    step(1'b0, 1'b1);
    chk("sat_hold", {16'd0, drop_cnt}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
